// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner
//
// Front end for the traffic light controller's side-road vehicle request.
// The raw loop-detector level is synchronised, debounced and qualified for a
// minimum presence time. The resulting request is held until the controller
// grants side green. The block also flags a detector stuck high and keeps a
// wrapping count of qualified vehicles.
//
// Ports:
//   i_clk            system clock, all state on the rising edge
//   i_reset          asynchronous, active-high reset
//   i_sensor_raw     raw detector level, asynchronous to i_clk
//   i_Side_green     side-road green lamp fed back from the controller
//   o_Vs             registered vehicle request to the controller
//   o_fault          registered, high while the detector is considered stuck
//   o_vehicle_count  registered 8-bit count of qualified vehicles, wraps
module vehicle_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_PRESENCE    = 8,
    parameter int STUCK_LIMIT     = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sensor_raw,
    input  logic       i_Side_green,
    output logic       o_Vs,
    output logic       o_fault,
    output logic [7:0] o_vehicle_count
);

    localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int QC_W = $clog2(MIN_PRESENCE + 1);
    localparam int SC_W = $clog2(STUCK_LIMIT + 1);

    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(MIN_PRESENCE - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STUCK_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        QUALIFY,
        REQUEST,
        SERVING,
        STUCK
    } state_t;

    logic            s1;
    logic            s2;
    logic            deb;
    logic [DC_W-1:0] dc;
    logic [SC_W-1:0] sc;
    logic [QC_W-1:0] qc;
    state_t          state;
    state_t          state_next;
    logic            stuck_hit;

    // Synchroniser, debouncer and stuck-high counter.
    // NOTE: every flop is cleared by reset; there is no memory array here, so
    // nothing is left to power up as X.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            dc  <= '0;
            sc  <= '0;
        end else begin
            // NOTE: non-blocking assignments let s2 take the old s1, which is
            // exactly the two-stage synchroniser behaviour.
            s1 <= i_sensor_raw;
            s2 <= s1;

            // The level flips only after s2 has disagreed for the full window.
            if (s2 != deb) begin
                if (dc == DC_LAST) begin
                    deb <= s2;
                    dc  <= '0;
                end else begin
                    dc <= dc + DC_W'(1);
                end
            end else begin
                dc <= '0;
            end

            // Continuous-high time, saturating so the stuck flag stays asserted.
            if (!deb) begin
                sc <= '0;
            end else if (sc != SC_LAST) begin
                sc <= sc + SC_W'(1);
            end
        end
    end

    assign stuck_hit = deb && (sc == SC_LAST);

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        if (stuck_hit && (state != STUCK)) begin
            // Stuck entry overrides every per-state rule.
            state_next = STUCK;
        end else begin
            unique case (state)
                IDLE:    if (deb) state_next = QUALIFY;
                QUALIFY: begin
                    if (!deb)               state_next = IDLE;
                    else if (qc == QC_LAST) state_next = REQUEST;
                end
                // Latched request: the detector level is ignored until green.
                REQUEST: if (i_Side_green)  state_next = SERVING;
                SERVING: if (!i_Side_green) state_next = IDLE;
                STUCK:   if (!deb)          state_next = IDLE;
                default:                    state_next = IDLE;
            endcase
        end
    end

    // State register, presence counter and outputs decoded from the next state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            qc              <= '0;
            o_Vs            <= 1'b0;
            o_fault         <= 1'b0;
            o_vehicle_count <= 8'd0;
        end else begin
            state <= state_next;

            if (state_next == QUALIFY) begin
                qc <= (state == QUALIFY) ? qc + QC_W'(1) : '0;
            end

            if ((state == QUALIFY) && (state_next == REQUEST)) begin
                o_vehicle_count <= o_vehicle_count + 8'd1;
            end

            unique case (state_next)
                REQUEST: begin o_Vs <= 1'b1; o_fault <= 1'b0; end
                // While served, keep requesting as long as a vehicle is present
                // so the controller can extend side green.
                SERVING: begin o_Vs <= deb;  o_fault <= 1'b0; end
                // Fail safe: a stuck detector still requests the side road.
                STUCK:   begin o_Vs <= 1'b1; o_fault <= 1'b1; end
                default: begin o_Vs <= 1'b0; o_fault <= 1'b0; end
            endcase
        end
    end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed testbench for vehicle_sensor_conditioner with default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_vehicle_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw;
    logic       green;
    logic       vs;
    logic       fault;
    logic [7:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vehicle_sensor_conditioner dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_sensor_raw    (raw),
        .i_Side_green    (green),
        .o_Vs            (vs),
        .o_fault         (fault),
        .o_vehicle_count (count)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One vehicle: 9-cycle raw pulse qualifies, then a green pulse serves it.
    task automatic vehicle();
        raw = 1'b1;
        repeat (9) tick();
        raw = 1'b0;
        repeat (6) tick();
        green = 1'b1;
        tick();
        green = 1'b0;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        raw   = 1'b0;
        green = 1'b0;
        repeat (2) tick();
        check("rst_vs",    vs,    0);
        check("rst_fault", fault, 0);
        check("rst_count", count, 0);

        // Raw held high from edge 0: request rises after edge 14.
        rst = 1'b0;
        raw = 1'b1;
        repeat (14) tick();
        check("lat_vs_e13",    vs,    0);
        check("lat_count_e13", count, 0);
        tick();
        check("lat_vs_e14",    vs,    1);
        check("lat_count_e14", count, 1);
        check("lat_fault",     fault, 0);

        // Serving with the vehicle still present: o_Vs follows deb.
        green = 1'b1;
        tick();
        check("serve_vs_enter", vs, 1);
        repeat (3) tick();
        check("serve_vs_hold", vs, 1);
        green = 1'b0;
        tick();
        check("serve_exit_vs", vs, 0);
        // IDLE re-qualifies: QUALIFY next edge, REQUEST 9 edges after exit.
        repeat (8) tick();
        check("requal_vs_pre", vs, 0);
        tick();
        check("requal_vs",    vs,    1);
        check("requal_count", count, 2);

        // Vehicle leaves while served: o_Vs drops once deb falls.
        raw   = 1'b0;
        green = 1'b1;
        tick();
        check("leave_vs_enter", vs, 1);
        repeat (10) tick();
        check("leave_vs_gone", vs, 0);
        green = 1'b0;
        tick();
        check("leave_idle_vs",    vs,    0);
        check("leave_idle_count", count, 2);

        // Green while idle is ignored.
        green = 1'b1;
        repeat (5) tick();
        check("idle_green_vs", vs, 0);
        green = 1'b0;

        // 3-cycle raw glitch never reaches the debounced level.
        raw = 1'b1;
        repeat (3) tick();
        raw = 1'b0;
        repeat (20) tick();
        check("glitch_vs",    vs,    0);
        check("glitch_count", count, 2);

        // 6-cycle presence is discarded in QUALIFY.
        raw = 1'b1;
        repeat (6) tick();
        raw = 1'b0;
        repeat (20) tick();
        check("short_vs",    vs,    0);
        check("short_count", count, 2);

        // 9-cycle presence qualifies and the request is latched.
        raw = 1'b1;
        repeat (9) tick();
        raw = 1'b0;
        repeat (5) tick();
        check("p9_vs_pre", vs, 0);
        tick();
        check("p9_vs",    vs,    1);
        check("p9_count", count, 3);
        repeat (10) tick();
        check("p9_latched", vs, 1);
        green = 1'b1;
        tick();
        check("p9_serve_vs", vs, 0);
        green = 1'b0;
        tick();
        check("p9_idle_vs",    vs,    0);
        check("p9_idle_count", count, 3);

        // Stuck high: STUCK entered at edge 1005 after the raw rise.
        raw = 1'b1;
        repeat (1005) tick();
        check("stuck_pre_fault", fault, 0);
        check("stuck_pre_vs",    vs,    1);
        tick();
        check("stuck_fault", fault, 1);
        check("stuck_vs",    vs,    1);
        check("stuck_count", count, 4);
        repeat (94) tick();
        check("stuck_hold_fault", fault, 1);
        raw = 1'b0;
        repeat (6) tick();
        check("unstuck_pre_fault", fault, 1);
        tick();
        check("unstuck_fault", fault, 0);
        check("unstuck_vs",    vs,    0);

        // Count wraps from 255 to 0.
        for (int i = 0; i < 251; i++) vehicle();
        check("wrap_255", count, 8'd255);
        vehicle();
        check("wrap_0", count, 8'd0);
        vehicle();
        check("wrap_1", count, 8'd1);

        // Asynchronous reset in the middle of QUALIFY.
        raw = 1'b1;
        repeat (10) tick();
        check("mid_q_vs", vs, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_vs",    vs,    0);
        check("arst_fault", fault, 0);
        check("arst_count", count, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (14) tick();
        check("post_rst_vs_pre", vs, 0);
        tick();
        check("post_rst_vs",    vs,    1);
        check("post_rst_count", count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
